// File: rtl/pico_regfile.sv
// ---------------------------------------------------------------------------
// pico_regfile -- picoMIPS general-purpose register file.
//
// NREGS x WIDTH registers with one synchronous write port and two
// registered read ports. gpr[0] is hardwired to zero. The register file
// feeds the ALU operand paths and is written back from the ALU/immediate
// result.
//
// Build option:
//   REGS_BYPASS_EN  when defined, a same-edge write to the register addressed
//                   by a read port is forwarded to that port's output.
//                   When undefined, the read returns the pre-write contents.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous reset, active-low (0 = reset asserted)
//   w        write enable
//   waddr    write address
//   wdata    write data
//   raddr1   read address, port 1
//   raddr2   read address, port 2
//   data1_q  registered read data, port 1 (1-cycle latency)
//   data2_q  registered read data, port 2 (1-cycle latency)
// ---------------------------------------------------------------------------
module pico_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] data1_q,
    output logic [WIDTH-1:0] data2_q
);

    logic [WIDTH-1:0] gpr [NREGS];

    logic             wr_en;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // Address 0 is never written, so gpr[0] holds its reset value of zero.
    assign wr_en = w && (waddr != '0);

    // Read mux: address 0 returns zero explicitly, optional forwarding of
    // the write data when the same non-zero register is written this edge.
    always_comb begin
        rd1 = (raddr1 == '0) ? '0 : gpr[raddr1];
        rd2 = (raddr2 == '0) ? '0 : gpr[raddr2];
`ifdef REGS_BYPASS_EN
        if (wr_en && (waddr == raddr1)) rd1 = wdata;
        if (wr_en && (waddr == raddr2)) rd2 = wdata;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpr <= '{default: '0};
        end else if (wr_en) begin
            gpr[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            data1_q <= rd1;
            data2_q <= rd2;
        end
    end

endmodule

// File: tb/tb_pico_regfile.sv
// ---------------------------------------------------------------------------
// tb_pico_regfile -- self-checking bench for pico_regfile (8 x 8 bits).
// A behavioural array model predicts both read ports one edge ahead;
// directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_pico_regfile;

`ifdef REGS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       w;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr1;
    logic [2:0] raddr2;
    logic [7:0] data1_q;
    logic [7:0] data2_q;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [8];
    logic [7:0] exp1;
    logic [7:0] exp2;

    pico_regfile #(.WIDTH(8), .NREGS(8), .AW(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .w      (w),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .data1_q(data1_q),
        .data2_q(data2_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, predicting outputs from the current inputs
    // and the pre-edge model contents. Returns 1 time unit after the edge.
    task automatic step();
        logic [7:0] n1;
        logic [7:0] n2;
        if (!reset) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'h00;
            n1 = 8'h00;
            n2 = 8'h00;
        end else begin
            n1 = (raddr1 == 3'd0) ? 8'h00 : mem[raddr1];
            n2 = (raddr2 == 3'd0) ? 8'h00 : mem[raddr2];
            if (BYP && w && waddr != 3'd0 && waddr == raddr1) n1 = wdata;
            if (BYP && w && waddr != 3'd0 && waddr == raddr2) n2 = wdata;
            if (w && waddr != 3'd0) mem[waddr] = wdata;
        end
        @(posedge clk);
        #1;
        exp1 = n1;
        exp2 = n2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        w = 1'b0; waddr = 3'd0; wdata = 8'h00; raddr1 = 3'd0; raddr2 = 3'd0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #2;
        tests++;
        if (data1_q !== 8'h00 || data2_q !== 8'h00) begin
            fails++;
            $display("FAIL reset_async: data1_q=%h data2_q=%h expected 00 00", data1_q, data2_q);
        end
        step();
        reset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            raddr1 = 3'(a);
            raddr2 = 3'(7 - a);
            step();
            tests++;
            if (data1_q !== 8'h00 || data2_q !== 8'h00 || exp1 !== 8'h00) begin
                fails++;
                $display("FAIL reset_read addr=%0d: data1_q=%h data2_q=%h expected 00 00", a, data1_q, data2_q);
            end
        end
    endtask

    task automatic test_write_read();
        w = 1'b1; waddr = 3'd1; wdata = 8'hA5;
        step();
        w = 1'b0; raddr1 = 3'd1; raddr2 = 3'd0;
        step();
        tests++;
        if (data1_q !== 8'hA5 || data2_q !== 8'h00) begin
            fails++;
            $display("FAIL write_read: data1_q=%h data2_q=%h expected a5 00", data1_q, data2_q);
        end
    endtask

    task automatic test_zero_write();
        w = 1'b1; waddr = 3'd0; wdata = 8'hFF;
        step();
        w = 1'b0; raddr1 = 3'd0; raddr2 = 3'd1;
        step();
        tests++;
        if (data1_q !== 8'h00 || data2_q !== 8'hA5) begin
            fails++;
            $display("FAIL zero_write: data1_q=%h data2_q=%h expected 00 a5", data1_q, data2_q);
        end
    endtask

    task automatic test_two_ports();
        w = 1'b1; waddr = 3'd2; wdata = 8'h5A;
        step();
        w = 1'b0; raddr1 = 3'd1; raddr2 = 3'd2;
        step();
        tests++;
        if (data1_q !== 8'hA5 || data2_q !== 8'h5A) begin
            fails++;
            $display("FAIL two_ports: data1_q=%h data2_q=%h expected a5 5a", data1_q, data2_q);
        end
        raddr1 = 3'd2; raddr2 = 3'd2;
        step();
        tests++;
        if (data1_q !== 8'h5A || data2_q !== 8'h5A) begin
            fails++;
            $display("FAIL same_reg_both_ports: data1_q=%h data2_q=%h expected 5a 5a", data1_q, data2_q);
        end
    endtask

    task automatic test_async_reset();
        raddr1 = 3'd1; raddr2 = 3'd2;
        step();
        #3;
        reset = 1'b0;
        #1;
        tests++;
        if (data1_q !== 8'h00 || data2_q !== 8'h00) begin
            fails++;
            $display("FAIL async_reset_mid_cycle: data1_q=%h data2_q=%h expected 00 00", data1_q, data2_q);
        end
        // Writes attempted while reset is held must be ignored.
        w = 1'b1; waddr = 3'd1; wdata = 8'h77;
        step();
        tests++;
        if (data1_q !== 8'h00 || data2_q !== 8'h00) begin
            fails++;
            $display("FAIL reset_held: data1_q=%h data2_q=%h expected 00 00", data1_q, data2_q);
        end
        w = 1'b0;
        reset = 1'b1;
        step();
        tests++;
        if (data1_q !== 8'h00 || data2_q !== 8'h00) begin
            fails++;
            $display("FAIL read_after_reset: data1_q=%h data2_q=%h expected 00 00", data1_q, data2_q);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] first;
        first = BYP ? 8'h3C : 8'h00;
        w = 1'b1; waddr = 3'd3; wdata = 8'h3C; raddr1 = 3'd3; raddr2 = 3'd3;
        step();
        tests++;
        if (data1_q !== first || data2_q !== first) begin
            fails++;
            $display("FAIL same_cycle_rw: data1_q=%h data2_q=%h expected %h %h", data1_q, data2_q, first, first);
        end
        w = 1'b0;
        step();
        tests++;
        if (data1_q !== 8'h3C || data2_q !== 8'h3C) begin
            fails++;
            $display("FAIL same_cycle_next: data1_q=%h data2_q=%h expected 3c 3c", data1_q, data2_q);
        end
        // Write to 0 with matching read address is never forwarded.
        w = 1'b1; waddr = 3'd0; wdata = 8'hEE; raddr1 = 3'd0; raddr2 = 3'd3;
        step();
        tests++;
        if (data1_q !== 8'h00 || data2_q !== 8'h3C) begin
            fails++;
            $display("FAIL zero_no_forward: data1_q=%h data2_q=%h expected 00 3c", data1_q, data2_q);
        end
        w = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            w      = 1'($urandom_range(0, 1));
            waddr  = 3'($urandom_range(0, 7));
            wdata  = 8'($urandom);
            raddr1 = 3'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            step();
            tests++;
            if (data1_q !== exp1) begin
                fails++;
                $display("FAIL random_port1 iter=%0d raddr1=%0d: got %h expected %h", n, raddr1, data1_q, exp1);
            end
            tests++;
            if (data2_q !== exp2) begin
                fails++;
                $display("FAIL random_port2 iter=%0d raddr2=%0d: got %h expected %h", n, raddr2, data2_q, exp2);
            end
        end
        w = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_write();
        test_two_ports();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
